// File: rtl/wisard_pkg.sv
// Shared definitions for the wisard stream generator.
//   state_t : stream FSM state encoding (IDLE=0, STREAM=1, GAP=2)
//   clog2   : ceiling log2, used to size the gap counter
package wisard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = int'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wisard_sample_buf.sv
// Two-slot sample buffer between the upstream handshake and the streamer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data into the write slot (caller gates with in_ready)
//   push_data    : one complete packed sample
//   pop          : release the read slot
//   in_ready     : low only while both slots are occupied
//   occupancy    : number of filled slots (0..2)
//   rd_data      : contents of the read slot
module wisard_sample_buf #(
    parameter int DATA_WIDTH = 392
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  in_ready,
    output logic [1:0]            occupancy,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] slots [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  full_q;
    logic [1:0]            occ_next;

    always_comb begin
        occ_next = occupancy + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= '0;
            full_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occ_next;
            full_q    <= (occ_next == 2'd2);
        end
    end

    // Slot contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Registered full flag, masked by reset so ready reads 0 while held in reset.
    assign in_ready = rst_n & ~full_q;
    assign rd_data  = slots[rd_ptr];

endmodule

// File: rtl/wisard_stream_gen.sv
// Serialises packed N_RAMS-address samples into the wisard core stream,
// one address per clock, with optional idle gap between samples.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_data holds a sample
//   in_ready    : a buffer slot is free
//   in_data     : packed sample, RAM i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   sop/eop     : first / last beat of a sample
//   sink_valid  : addr/index valid
//   addr, index : RAM address and RAM index of the beat
//   busy        : sample buffered or FSM not idle
//   sample_cnt  : number of eop beats issued (wraps)
module wisard_stream_gen
    import wisard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int INDEX_WIDTH   = 6,
    parameter int N_RAMS        = 49,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_RAMS*ADDRESS_WIDTH-1:0] in_data,
    output logic                            sop,
    output logic                            sink_valid,
    output logic                            eop,
    output logic [ADDRESS_WIDTH-1:0]        addr,
    output logic [INDEX_WIDTH-1:0]          index,
    output logic                            busy,
    output logic [31:0]                     sample_cnt
);

    localparam int DW = N_RAMS * ADDRESS_WIDTH;
    localparam int GW = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(N_RAMS - 1);

    logic                     push;
    logic                     pop;
    logic [1:0]               occ;
    logic [DW-1:0]            rd_data;

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic                     issue;
    logic [INDEX_WIDTH-1:0]   beat;
    logic [ADDRESS_WIDTH-1:0] beat_addr;

    assign push = in_valid && in_ready;

    wisard_sample_buf #(
        .DATA_WIDTH(DW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .in_ready  (in_ready),
        .occupancy (occ),
        .rd_data   (rd_data)
    );

    // issue/beat name the beat registered onto the outputs at this edge;
    // idx_q holds the next beat to issue while in STREAM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        beat    = '0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (occ != '0) begin
                    issue = 1'b1;
                end
            end
            STREAM: begin
                issue = 1'b1;
                beat  = idx_q;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            if (beat == LAST) begin
                pop   = 1'b1;
                idx_d = '0;
                if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES - 1);
                end else if (occ > 2'd1 || push) begin
                    // A sample behind the one being popped (or arriving now) streams back-to-back.
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                state_d = STREAM;
                idx_d   = beat + 1'b1;
            end
        end
    end

    always_comb begin
        beat_addr = rd_data[beat*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            sink_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            addr       <= '0;
            index      <= '0;
            sample_cnt <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            sink_valid <= issue;
            sop        <= issue && (beat == '0);
            eop        <= issue && (beat == LAST);
            addr       <= issue ? beat_addr : '0;
            index      <= issue ? beat : '0;
            if (pop) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
        end
    end

    assign busy = (occ != '0) || (state_q != IDLE);

endmodule
